instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
// - Multi-cycle control front end driving the regfile/ALU datapath control interface (AD1/AD2/AD3/WE3/ALUsrc/Immop) and consuming its EQ flag.
// - Fetches 32-bit instructions over a req/ack memory port, decodes ADDI/ADD/BNE, sequences writeback and branches.
// - Sits between instruction memory and the datapath top.
// PARAMETERS
// - DATA_WIDTH  32  datapath word width (Immop width)
// - ADD_WIDTH   5   register address width
// - PC_WIDTH    32  program counter / imem address width
// - RESET_PC    0   PC value loaded on reset
// PORTS
// - clk         in   1           single clock, rising edge
// - rst         in   1           asynchronous, active-high reset
// - imem_req    out  1           fetch request
// - imem_addr   out  PC_WIDTH    fetch address (= pc)
// - imem_ack    in   1           fetch data valid this cycle
// - imem_rdata  in   32          instruction word
// - AD1/AD2/AD3 out  ADD_WIDTH   rs1 / rs2 / rd to register file
// - WE3         out  1           register write enable
// - ALUsrc      out  1           1 = Immop as ALU operand 2, 0 = RD2
// - Immop       out  DATA_WIDTH  sign-extended immediate
// - EQ          in   1           datapath flag: ALU operand1 == operand2
// - pc          out  PC_WIDTH    current PC
// - halted      out  1           sticky halt indicator
// BEHAVIOUR
// - Reset (async): state=FETCH, pc=RESET_PC, IR=0, imem_req=0, WE3=0, AD1/AD2/AD3=0, ALUsrc=0, Immop=0, halted=0.
// - FSM FETCH -> DECODE -> EXEC -> FETCH; HALT terminal until rst.
// - FETCH: imem_req=1, imem_addr=pc held stable until imem_ack sampled high; IR<=imem_rdata on that edge -> DECODE.
//   ack with req low ignored; ack in first FETCH cycle accepted (min 1-cycle fetch).
// - DECODE: AD1/AD2/AD3/ALUsrc/Immop driven from IR (registered, stable through EXEC); WE3=0.
//   ADDI (op 0010011,f3 000): AD1=rs1, AD3=rd, ALUsrc=1, Immop=sext(IR[31:20]).
//   ADD (op 0110011,f3 000,f7 0): AD1=rs1, AD2=rs2, AD3=rd, ALUsrc=0.
//   BNE (op 1100011,f3 001): AD1=rs1, AD2=rs2, ALUsrc=0, AD3=0, Immop=sext B-imm {IR[31],IR[7],IR[30:25],IR[11:8],0}.
//   Any other encoding -> HALT next edge, pc unchanged, WE3 never asserted.
// - EXEC (1 cycle): ADDI/ADD: WE3=1 for exactly this cycle unless rd==0 (WE3=0); pc<=pc+4.
//   BNE: sample EQ; EQ=0 -> pc<=pc+Immop[PC_WIDTH-1:0]; EQ=1 -> pc<=pc+4. WE3=0.
//   Target with bit1 set -> HALT, pc unchanged.
// - Latency: 3 cycles/instruction with zero-wait memory (FETCH+DECODE+EXEC); +N per ack wait cycle.
// - PC arithmetic modulo 2^PC_WIDTH; wrap from max to 0 is silent, no halt.
// - HALT: halted=1, imem_req=0, WE3=0, other outputs hold last values.
// - rst mid-fetch or mid-EXEC: outputs go to reset values immediately; pending write abandoned.
// CONFIGURATION
// - INSTRET_CNT_EN defined: extra port instret out 32, zero on reset, +1 at end of each completed EXEC
//   (retired ADDI/ADD/BNE incl. rd==0), wraps at 2^32, frozen in HALT.
// - Undefined: no instret port, no counter logic.
// TESTING
// - rst high then low, imem_ack tied 1: pc=0, imem_req=1 cycle 1, IR fetched, WE3 first high in cycle 3.
// - ADDI x10,x0,5 (0x00500513): DECODE shows AD1=0, AD3=10, ALUsrc=1, Immop=5; WE3=1 one cycle; pc 0->4.
// - BNE x11,x0,-8 at pc=8 (0xFE059CE3) with EQ=0 -> pc=0; with EQ=1 -> pc=12; WE3 stays 0.
// - ADD x0,x1,x2 (0x00208033): WE3 remains 0; pc advances by 4; with INSTRET_CNT_EN instret +1.
// - imem_ack delayed 3 cycles: imem_req and imem_addr stable throughout; instruction period = 6 cycles.
// - Word 0xFFFFFFFF: halted=1 after DECODE, imem_req=0, pc unchanged; rst asserted mid-HALT returns all outputs to reset values.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control front end for the regfile/ALU datapath. Fetches 32-bit
// instructions over a req/ack memory port, decodes ADDI/ADD/BNE, drives the
// register-file addresses, write enable and immediate, and resolves BNE
// branches from the datapath EQ flag.
// FSM: FETCH -> DECODE -> EXEC -> FETCH, HALT is terminal until rst.
//
// Ports:
//   clk, rst              single rising-edge clock, async active-high reset
//   imem_req/imem_addr    fetch request and address (address = pc)
//   imem_ack/imem_rdata   fetch data valid strobe and instruction word
//   AD1/AD2/AD3           rs1 / rs2 / rd register addresses
//   WE3                   register write enable (one EXEC cycle)
//   ALUsrc                1 = Immop is ALU operand 2, 0 = RD2
//   Immop                 sign-extended immediate
//   EQ                    datapath flag, ALU operand1 == operand2
//   pc                    current program counter
//   halted                sticky halt indicator
//
// Optional feature: define INSTRET_CNT_EN to add the 32-bit 'instret' output,
// a retired-instruction counter (zero on reset, frozen in HALT).
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ADD_WIDTH  = 5,
   parameter int                  PC_WIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [PC_WIDTH-1:0]   imem_addr,
   input  logic                  imem_ack,
   input  logic [31:0]           imem_rdata,
   output logic [ADD_WIDTH-1:0]  AD1,
   output logic [ADD_WIDTH-1:0]  AD2,
   output logic [ADD_WIDTH-1:0]  AD3,
   output logic                  WE3,
   output logic                  ALUsrc,
   output logic [DATA_WIDTH-1:0] Immop,
   input  logic                  EQ,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  halted
`ifdef INSTRET_CNT_EN
   ,
   output logic [31:0]           instret
`endif
);

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_BAD  = 2'd0,
      K_ADDI = 2'd1,
      K_ADD  = 2'd2,
      K_BNE  = 2'd3
   } kind_t;

   // Classify an instruction word; anything not recognised is K_BAD.
   function automatic kind_t decode_kind(input logic [31:0] w);
      kind_t k;
      k = K_BAD;
      if ((w[6:0] == 7'b0010011) && (w[14:12] == 3'b000)) begin
         k = K_ADDI;
      end else if ((w[6:0] == 7'b0110011) && (w[14:12] == 3'b000) && (w[31:25] == 7'b0000000)) begin
         k = K_ADD;
      end else if ((w[6:0] == 7'b1100011) && (w[14:12] == 3'b001)) begin
         k = K_BNE;
      end else begin
         k = K_BAD;
      end
      return k;
   endfunction

   state_t                state_r, state_s;
   kind_t                 kind_r, kind_s;
   logic [PC_WIDTH-1:0]   pc_r, pc_s, tgt_s;
   logic                  req_r, req_s;
   logic                  we3_r, we3_s;
   logic [ADD_WIDTH-1:0]  ad1_r, ad1_s, ad2_r, ad2_s, ad3_r, ad3_s;
   logic                  alusrc_r, alusrc_s;
   logic [DATA_WIDTH-1:0] imm_r, imm_s;
   logic                  halted_r, halted_s;
`ifdef INSTRET_CNT_EN
   logic [31:0]           instret_r, instret_s;
`endif

   // Next-state and next-output logic; decode happens on the accepting fetch
   // edge so the register addresses are already valid during DECODE.
   always_comb begin
      state_s  = state_r;
      kind_s   = kind_r;
      pc_s     = pc_r;
      req_s    = req_r;
      we3_s    = 1'b0;
      ad1_s    = ad1_r;
      ad2_s    = ad2_r;
      ad3_s    = ad3_r;
      alusrc_s = alusrc_r;
      imm_s    = imm_r;
      halted_s = halted_r;
      tgt_s    = pc_r + PC_WIDTH'(32'd4);
`ifdef INSTRET_CNT_EN
      instret_s = instret_r;
`endif
      case (state_r)
         ST_FETCH: begin
            // An ack only counts while our request is actually up.
            if (req_r && imem_ack) begin
               req_s   = 1'b0;
               kind_s  = decode_kind(imem_rdata);
               state_s = ST_DECODE;
               case (kind_s)
                  K_ADDI: begin
                     ad1_s    = ADD_WIDTH'(imem_rdata[19:15]);
                     ad2_s    = {ADD_WIDTH{1'b0}};
                     ad3_s    = ADD_WIDTH'(imem_rdata[11:7]);
                     alusrc_s = 1'b1;
                     imm_s    = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:20]};
                  end
                  K_ADD: begin
                     ad1_s    = ADD_WIDTH'(imem_rdata[19:15]);
                     ad2_s    = ADD_WIDTH'(imem_rdata[24:20]);
                     ad3_s    = ADD_WIDTH'(imem_rdata[11:7]);
                     alusrc_s = 1'b0;
                     imm_s    = {DATA_WIDTH{1'b0}};
                  end
                  K_BNE: begin
                     ad1_s    = ADD_WIDTH'(imem_rdata[19:15]);
                     ad2_s    = ADD_WIDTH'(imem_rdata[24:20]);
                     ad3_s    = {ADD_WIDTH{1'b0}};
                     alusrc_s = 1'b0;
                     imm_s    = {{(DATA_WIDTH-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                                 imem_rdata[30:25], imem_rdata[11:8], 1'b0};
                  end
                  default: begin
                     // Illegal word: datapath controls keep their last values.
                     alusrc_s = alusrc_r;
                  end
               endcase
            end else begin
               req_s = 1'b1;
            end
         end
         ST_DECODE: begin
            if (kind_r == K_BAD) begin
               state_s  = ST_HALT;
               halted_s = 1'b1;
            end else begin
               state_s = ST_EXEC;
               // Writes to x0 are suppressed rather than issued.
               we3_s   = (kind_r != K_BNE) && (ad3_r != {ADD_WIDTH{1'b0}});
            end
         end
         ST_EXEC: begin
            if ((kind_r == K_BNE) && !EQ) begin
               tgt_s = pc_r + imm_r[PC_WIDTH-1:0];
            end else begin
               tgt_s = pc_r + PC_WIDTH'(32'd4);
            end
            // A target that is not word aligned stops the machine in place.
            if (tgt_s[1]) begin
               state_s  = ST_HALT;
               halted_s = 1'b1;
               req_s    = 1'b0;
            end else begin
               pc_s    = tgt_s;
               state_s = ST_FETCH;
               req_s   = 1'b1;
`ifdef INSTRET_CNT_EN
               instret_s = instret_r + 32'd1;
`endif
            end
         end
         ST_HALT: begin
            halted_s = 1'b1;
            req_s    = 1'b0;
         end
         default: begin
            state_s  = ST_HALT;
            halted_s = 1'b1;
            req_s    = 1'b0;
         end
      endcase
   end

   // State and registered-output update with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_FETCH;
         kind_r   <= K_BAD;
         pc_r     <= RESET_PC;
         req_r    <= 1'b0;
         we3_r    <= 1'b0;
         ad1_r    <= {ADD_WIDTH{1'b0}};
         ad2_r    <= {ADD_WIDTH{1'b0}};
         ad3_r    <= {ADD_WIDTH{1'b0}};
         alusrc_r <= 1'b0;
         imm_r    <= {DATA_WIDTH{1'b0}};
         halted_r <= 1'b0;
`ifdef INSTRET_CNT_EN
         instret_r <= 32'd0;
`endif
      end else begin
         state_r  <= state_s;
         kind_r   <= kind_s;
         pc_r     <= pc_s;
         req_r    <= req_s;
         we3_r    <= we3_s;
         ad1_r    <= ad1_s;
         ad2_r    <= ad2_s;
         ad3_r    <= ad3_s;
         alusrc_r <= alusrc_s;
         imm_r    <= imm_s;
         halted_r <= halted_s;
`ifdef INSTRET_CNT_EN
         instret_r <= instret_s;
`endif
      end
   end

   assign imem_req  = req_r;
   assign imem_addr = pc_r;
   assign pc        = pc_r;
   assign AD1       = ad1_r;
   assign AD2       = ad2_r;
   assign AD3       = ad3_r;
   assign WE3       = we3_r;
   assign ALUsrc    = alusrc_r;
   assign Immop     = imm_r;
   assign halted    = halted_r;
`ifdef INSTRET_CNT_EN
   assign instret   = instret_r;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed, self-checking bench for instr_sequencer. The bench plays the
// instruction memory and the datapath EQ flag; expected decode/writeback/pc
// results are pushed to a scoreboard when an instruction word is supplied and
// popped when the sequencer presents its decode outputs.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [4:0]  AD1, AD2, AD3;
   logic        WE3;
   logic        ALUsrc;
   logic [31:0] Immop;
   logic        EQ = 1'b0;
   logic [31:0] pc;
   logic        halted;
`ifdef INSTRET_CNT_EN
   logic [31:0] instret;
`endif

   instr_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .AD1        (AD1),
      .AD2        (AD2),
      .AD3        (AD3),
      .WE3        (WE3),
      .ALUsrc     (ALUsrc),
      .Immop      (Immop),
      .EQ         (EQ),
      .pc         (pc),
      .halted     (halted)
`ifdef INSTRET_CNT_EN
      ,
      .instret    (instret)
`endif
   );

   always #5 clk = ~clk;

   // kind: 0 = retires normally, 1 = halts after EXEC, 2 = halts after DECODE
   typedef struct {
      int          kind;
      logic [4:0]  ad1;
      logic [4:0]  ad2;
      logic [4:0]  ad3;
      logic        src;
      logic [31:0] imm;
      logic        we3;
      logic [31:0] npc;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] cur_pc = 32'd0;
   logic [31:0] exp_instret = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input int kind, input logic [4:0] ad1, input logic [4:0] ad2,
                               input logic [4:0] ad3, input logic src, input logic [31:0] imm,
                               input logic we3, input logic [31:0] npc);
      exp_t e;
      e.kind = kind; e.ad1 = ad1; e.ad2 = ad2; e.ad3 = ad3;
      e.src = src; e.imm = imm; e.we3 = we3; e.npc = npc;
      return e;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_req"},    imem_req,  32'd0);
      chk({tag, "_addr"},   imem_addr, 32'd0);
      chk({tag, "_pc"},     pc,        32'd0);
      chk({tag, "_we3"},    WE3,       32'd0);
      chk({tag, "_ad1"},    AD1,       32'd0);
      chk({tag, "_ad2"},    AD2,       32'd0);
      chk({tag, "_ad3"},    AD3,       32'd0);
      chk({tag, "_alusrc"}, ALUsrc,    32'd0);
      chk({tag, "_immop"},  Immop,     32'd0);
      chk({tag, "_halted"}, halted,    32'd0);
`ifdef INSTRET_CNT_EN
      chk({tag, "_instret"}, instret,  32'd0);
`endif
   endtask

   // Assert rst (outputs must clear immediately), release it with a stray ack
   // present while the request is still low, then expect a clean first fetch.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      imem_ack = 1'b0;
      EQ = 1'b0;
      #1;
      check_reset(tag);
      @(negedge clk);
      imem_ack = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      rst = 1'b0;
      @(negedge clk);
      chk({tag, "_first_req"},  imem_req,  32'd1);
      chk({tag, "_first_addr"}, imem_addr, 32'd0);
      chk({tag, "_no_halt"},    halted,    32'd0);
      imem_ack = 1'b0;
      cur_pc = 32'd0;
      exp_instret = 32'd0;
   endtask

   // Runs one instruction starting at a negedge in FETCH with imem_req high.
   task automatic run_instr(input string tag, input logic [31:0] word, input int waits,
                            input logic eq, input exp_t e);
      exp_t x;
      sb.push_back(e);
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         chk({tag, "_wait_req"},  imem_req,  32'd1);
         chk({tag, "_wait_addr"}, imem_addr, cur_pc);
         @(negedge clk);
      end
      chk({tag, "_req"},  imem_req,  32'd1);
      chk({tag, "_addr"}, imem_addr, cur_pc);
      imem_ack = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack = 1'b0;
      imem_rdata = 32'd0;
      x = sb.pop_front();
      chk({tag, "_dec_req"}, imem_req, 32'd0);
      chk({tag, "_dec_we3"}, WE3,      32'd0);
      if (x.kind != 2) begin
         chk({tag, "_ad1"},    AD1,    {27'd0, x.ad1});
         chk({tag, "_ad2"},    AD2,    {27'd0, x.ad2});
         chk({tag, "_ad3"},    AD3,    {27'd0, x.ad3});
         chk({tag, "_alusrc"}, ALUsrc, {31'd0, x.src});
         chk({tag, "_immop"},  Immop,  x.imm);
      end
      EQ = eq;
      @(negedge clk);
      if (x.kind == 2) begin
         chk({tag, "_halted"}, halted, 32'd1);
         chk({tag, "_h_req"},  imem_req, 32'd0);
         chk({tag, "_h_pc"},   pc, cur_pc);
         chk({tag, "_h_we3"},  WE3, 32'd0);
      end else begin
         chk({tag, "_exec_we3"}, WE3, {31'd0, x.we3});
         chk({tag, "_exec_pc"},  pc, cur_pc);
         @(negedge clk);
         chk({tag, "_post_we3"}, WE3, 32'd0);
         if (x.kind == 1) begin
            chk({tag, "_halted"}, halted, 32'd1);
            chk({tag, "_h_req"},  imem_req, 32'd0);
            chk({tag, "_h_pc"},   pc, cur_pc);
         end else begin
            exp_instret = exp_instret + 32'd1;
            cur_pc = x.npc;
            chk({tag, "_npc"},     pc, x.npc);
            chk({tag, "_nreq"},    imem_req, 32'd1);
            chk({tag, "_nhalted"}, halted, 32'd0);
         end
      end
`ifdef INSTRET_CNT_EN
      chk({tag, "_instret"}, instret, exp_instret);
`endif
      if (x.kind != 0) begin
         // Halt must be sticky with the request kept low.
         @(negedge clk);
         chk({tag, "_stay_halted"}, halted, 32'd1);
         chk({tag, "_stay_req"},    imem_req, 32'd0);
         chk({tag, "_stay_pc"},     pc, cur_pc);
`ifdef INSTRET_CNT_EN
         chk({tag, "_stay_instret"}, instret, exp_instret);
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      do_reset("rst0");
      run_instr("addi_x10",  32'h0050_0513, 0, 1'b0, mk(0, 5'd0,  5'd0, 5'd10, 1'b1, 32'd5,         1'b1, 32'd4));
      run_instr("add_x0",    32'h0020_8033, 0, 1'b0, mk(0, 5'd1,  5'd2, 5'd0,  1'b0, 32'd0,         1'b0, 32'd8));
      run_instr("bne_eq1",   32'hFE05_9CE3, 0, 1'b1, mk(0, 5'd11, 5'd0, 5'd0,  1'b0, 32'hFFFF_FFF8, 1'b0, 32'd12));
      run_instr("addi_wait", 32'hFFF5_0293, 3, 1'b0, mk(0, 5'd10, 5'd0, 5'd5,  1'b1, 32'hFFFF_FFFF, 1'b1, 32'd16));
      run_instr("bne_eq0",   32'hFE05_9CE3, 0, 1'b0, mk(0, 5'd11, 5'd0, 5'd0,  1'b0, 32'hFFFF_FFF8, 1'b0, 32'd8));
      run_instr("add_x3",    32'h0020_81B3, 1, 1'b0, mk(0, 5'd1,  5'd2, 5'd3,  1'b0, 32'd0,         1'b1, 32'd12));
      run_instr("bne_misal", 32'h0020_9163, 0, 1'b0, mk(1, 5'd1,  5'd2, 5'd0,  1'b0, 32'd2,         1'b0, 32'd12));

      // Reset while halted.
      do_reset("rst_halt");

      // Reset in the EXEC cycle of a write: the write must vanish at once.
      imem_ack = 1'b1;
      imem_rdata = 32'h0050_0513;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      chk("abort_exec_we3", WE3, 32'd1);
      do_reset("rst_exec");

      // Backward branch from 4 wraps pc below zero, then wraps back to 0.
      run_instr("addi_again", 32'h0050_0513, 0, 1'b0, mk(0, 5'd0,  5'd0, 5'd10, 1'b1, 32'd5,         1'b1, 32'd4));
      run_instr("bne_wrap",   32'hFE05_9CE3, 0, 1'b0, mk(0, 5'd11, 5'd0, 5'd0,  1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFFC));
      run_instr("nop_wrap",   32'h0000_0013, 2, 1'b0, mk(0, 5'd0,  5'd0, 5'd0,  1'b1, 32'd0,         1'b0, 32'd0));

      // Illegal encoding halts straight out of DECODE.
      run_instr("illegal",    32'hFFFF_FFFF, 0, 1'b0, mk(2, 5'd0,  5'd0, 5'd0,  1'b0, 32'd0,         1'b0, 32'd0));
      do_reset("rst_end");

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
